// File: rtl/chirp_phase_accum_if.sv
// chirp_phase_accum_if: control/tuning inputs and ROM-address outputs of the chirp phase accumulator
interface chirp_phase_accum_if #(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 12,
  parameter int CNT_W   = 27,
  parameter int NIMP_W  = 5
);
  logic [1:0]         SIGNAL_TYPE;
  logic [PHASE_W-1:0] FCW_START;
  logic [PHASE_W-1:0] FCW_DELTA;
  logic [CNT_W-1:0]   IMP_SAMPLES;
  logic [CNT_W-1:0]   PERIOD_SAMPLES;
  logic [NIMP_W-1:0]  NUM_OF_IMP;
  logic               SIGN_START_GEN;
  logic               OUT_REG_READY;
  logic [ADDR_W-1:0]  ROM_ADDRESS;
  logic               ADDR_VALID;
  logic               SIGN_START_CALC;
  logic               SIGN_STOP_CALC;
  logic               BUSY;
  modport master (
    output SIGNAL_TYPE, FCW_START, FCW_DELTA, IMP_SAMPLES, PERIOD_SAMPLES, NUM_OF_IMP,
           SIGN_START_GEN, OUT_REG_READY,
    input  ROM_ADDRESS, ADDR_VALID, SIGN_START_CALC, SIGN_STOP_CALC, BUSY
  );
  modport slave (
    input  SIGNAL_TYPE, FCW_START, FCW_DELTA, IMP_SAMPLES, PERIOD_SAMPLES, NUM_OF_IMP,
           SIGN_START_GEN, OUT_REG_READY,
    output ROM_ADDRESS, ADDR_VALID, SIGN_START_CALC, SIGN_STOP_CALC, BUSY
  );
endinterface

// File: rtl/chirp_phase_accum.sv
// chirp_phase_accum: tone/V/up/down-chirp burst phase accumulator feeding a sine ROM; define PHASE_DITHER_EN for LFSR phase dither
module chirp_phase_accum #(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 12,
  parameter int CNT_W   = 27,
  parameter int NIMP_W  = 5
) (
  input logic CLK,
  input logic RESET,
  chirp_phase_accum_if.slave b
);
  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
  state_t st, st_nx;
  logic [1:0]         typ_q, typ;
  logic [PHASE_W-1:0] f0_q, d_q, phase, fcw, f0, d, ph, fc, fc_nx;
  logic [CNT_W-1:0]   imp_q, eff_q, cnt, imp, n_cnt, half;
  logic [NIMP_W-1:0]  nimp_q, ip, nimp, n_ip;
  logic               acc, run, act, wrap, newp, in_pulse, last;
  logic [ADDR_W-1:0]  addr_q, addr_nx;
  logic               valid_q, start_q, stop_q, busy_q;
  assign b.ROM_ADDRESS     = addr_q;
  assign b.ADDR_VALID      = valid_q;
  assign b.SIGN_START_CALC = start_q;
  assign b.SIGN_STOP_CALC  = stop_q;
  assign b.BUSY            = busy_q;
  // Next-sample decode: each edge produces the sample that becomes visible after it
  always_comb begin
    acc = st == IDLE && b.SIGN_START_GEN && b.OUT_REG_READY && b.NUM_OF_IMP != '0 && b.IMP_SAMPLES != '0;
    run = st != IDLE && !stop_q;
    act = acc || run;
    wrap = run && cnt == eff_q - 1'b1;
    newp = acc || wrap;
    typ = acc ? b.SIGNAL_TYPE : typ_q;
    f0 = acc ? b.FCW_START : f0_q;
    d = acc ? b.FCW_DELTA : d_q;
    imp = acc ? b.IMP_SAMPLES : imp_q;
    nimp = acc ? b.NUM_OF_IMP : nimp_q;
    n_cnt = newp ? '0 : cnt + 1'b1;
    n_ip = acc ? '0 : wrap ? ip + 1'b1 : ip;
    in_pulse = act && n_cnt < imp;
    half = imp >> 1;
    ph = newp ? '0 : phase;
    fc = newp ? f0 : fcw;
    fc_nx = typ == 2'd0 ? fc : (typ == 2'd2 || (typ == 2'd1 && n_cnt >= half)) ? fc + d : fc - d;
    last = act && n_ip == nimp - 1'b1 && n_cnt == imp - 1'b1;
    st_nx = !act ? IDLE : in_pulse ? PULSE : GAP;
  end
`ifdef PHASE_DITHER_EN
  localparam int L = PHASE_W - ADDR_W;
  localparam logic [L-1:0] TAPS = L'(L == 8 ? 32'hB8 : L == 12 ? 32'h829 : L == 16 ? 32'hB400 :
                                     L == 24 ? 32'hE10000 : 32'h90000);
  logic [L-1:0]       lfsr, lfsr_cur, lfsr_nx;
  logic [PHASE_W-1:0] ph_d;
  // Galois LFSR reseeded per burst, advancing only on pulse samples
  always_comb begin
    lfsr_cur = acc ? L'(1) : lfsr;
    lfsr_nx = in_pulse ? ((lfsr_cur >> 1) ^ (lfsr_cur[0] ? TAPS : '0)) : lfsr_cur;
    ph_d = ph + PHASE_W'(lfsr_cur);
  end
  // LFSR state register
  always_ff @(posedge CLK) lfsr <= RESET ? L'(1) : lfsr_nx;
  assign addr_nx = ph_d[PHASE_W-1 -: ADDR_W];
`else
  assign addr_nx = ph[PHASE_W-1 -: ADDR_W];
`endif
  // State, burst parameters, accumulators and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      st <= IDLE;
      typ_q <= '0;
      f0_q <= '0;
      d_q <= '0;
      imp_q <= '0;
      eff_q <= '0;
      nimp_q <= '0;
      cnt <= '0;
      ip <= '0;
      phase <= '0;
      fcw <= '0;
      addr_q <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      stop_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      st <= st_nx;
      if (acc) begin
        typ_q <= b.SIGNAL_TYPE;
        f0_q <= b.FCW_START;
        d_q <= b.FCW_DELTA;
        imp_q <= b.IMP_SAMPLES;
        eff_q <= b.PERIOD_SAMPLES > b.IMP_SAMPLES ? b.PERIOD_SAMPLES : b.IMP_SAMPLES;
        nimp_q <= b.NUM_OF_IMP;
      end
      cnt <= act ? n_cnt : '0;
      ip <= act ? n_ip : '0;
      phase <= act ? ph + fc : '0;
      fcw <= act ? fc_nx : '0;
      addr_q <= in_pulse ? addr_nx : '0;
      valid_q <= act;
      start_q <= acc;
      stop_q <= last;
      busy_q <= act;
    end
  end
endmodule
